// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: prefix FSM
// encoding, special byte values and the packed key-event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_FC = 8'hFC;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // Frame layout {stop, parity, d7..d0, start}; parity is odd over data+parity.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO for key events. The head entry is read straight from
// the storage array at the read pointer; no write-to-read fall-through.
module ps2_evt_fifo #(
  parameter int AW = 2,
  parameter int W  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty     = (r_wr == r_rd);
  assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= din;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: validates frames, walks the E0/F0 prefix protocol,
// queues {ext, brk, code} events and tracks errors, timeouts and overflow.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [10:0] frame_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_code,
  output logic        evt_ext,
  output logic        evt_brk,
  output logic        bat_ok,
  output logic        err_pulse,
  output logic [7:0]  err_cnt,
  output logic        overflow,
  output logic        rx_flush,
  output logic [1:0]  dbg_state
);

  // Event handshake: the head entry transfers on any rising edge where
  // evt_valid & evt_ready; evt_valid never drops until that transfer happens.

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t          r_state;
  state_t          w_nxt;
  state_t          w_cur;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_pulse;
  logic [7:0]      r_err_cnt;
  logic            r_overflow;
  logic            r_bat_ok;
  logic            r_flush;

  logic [7:0]      w_byte;
  logic            w_good;
  logic            w_bad;
  logic            w_timeout;
  logic            w_push;
  evt_t            w_evt;
  logic            w_err_proto;
  logic            w_bat_set;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_drop;
  logic            w_err;
  logic [EVT_W-1:0] w_head_bits;
  evt_t            w_head;

  assign w_byte    = frame_data[8:1];
  assign w_good    = frame_valid & frame_ok(frame_data);
  assign w_bad     = frame_valid & ~frame_ok(frame_data);
  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC));

  always_comb begin
    w_nxt       = r_state;
    w_push      = 1'b0;
    w_evt       = '0;
    w_err_proto = 1'b0;
    w_bat_set   = 1'b0;
    // A frame landing on the timeout cycle is decoded as if from IDLE.
    w_cur       = w_timeout ? ST_IDLE : r_state;
    if (w_timeout) begin
      w_nxt       = ST_IDLE;
      w_err_proto = 1'b1;
    end
    if (w_bad) begin
      w_nxt       = ST_IDLE;
      w_err_proto = 1'b1;
    end else if (w_good) begin
      w_nxt = w_cur;
      if (w_byte == B_00 || w_byte == B_FF) begin
        w_err_proto = 1'b1;
        w_nxt       = ST_IDLE;
      end else begin
        case (w_cur)
          ST_IDLE: begin
            if (w_byte == B_E0)      w_nxt = ST_EXT;
            else if (w_byte == B_F0) w_nxt = ST_BRK;
            else if (w_byte == B_AA) w_bat_set = 1'b1;
            else if (w_byte == B_FA || w_byte == B_EE ||
                     w_byte == B_FE || w_byte == B_FC) w_nxt = ST_IDLE;
            else begin
              w_push = 1'b1;
              w_evt  = '{ext: 1'b0, brk: 1'b0, code: w_byte};
            end
          end
          ST_EXT: begin
            if (w_byte == B_F0)      w_nxt = ST_EXT_BRK;
            else if (w_byte == B_E0) w_err_proto = 1'b1;
            else begin
              w_push = 1'b1;
              w_evt  = '{ext: 1'b1, brk: 1'b0, code: w_byte};
              w_nxt  = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            w_nxt = ST_IDLE;
            if (w_byte == B_F0 || w_byte == B_E0) w_err_proto = 1'b1;
            else begin
              w_push = 1'b1;
              w_evt  = '{ext: (w_cur == ST_EXT_BRK), brk: 1'b1, code: w_byte};
            end
          end
          default: w_nxt = ST_IDLE;
        endcase
      end
    end
  end

  assign w_pop  = ~w_empty & evt_ready;
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_err  = w_err_proto | w_drop;

  ps2_evt_fifo #(
    .AW (FIFO_AW),
    .W  (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_evt),
    .dout  (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_to_cnt    <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_bat_ok    <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_err_pulse <= w_err;
      r_flush     <= w_bad;
      if (r_state == ST_IDLE || w_good || w_timeout) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_drop)    r_overflow <= 1'b1;
      if (w_bat_set) r_bat_ok   <= 1'b1;
    end
  end

  assign w_head    = evt_t'(w_head_bits);
  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_brk   = w_head.brk;
  assign bat_ok    = r_bat_ok;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign overflow  = r_overflow;
  assign rx_flush  = r_flush;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: vector table for byte sequences plus
// hand-written timeout, overflow, full-with-pop and reset sequences.
module tb_ps2_scan_ctrl;

  localparam int TO  = 40;
  localparam int AW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [10:0] frame_data = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_brk;
  logic        bat_ok;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic        overflow;
  logic        rx_flush;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_err_cnt = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic [1:0] bad;      // 0 good, 1 parity, 2 start, 3 stop
    logic       has_evt;
    logic [9:0] evt;      // {ext, brk, code}
    logic       exp_err;
    logic       exp_flush;
  } vec_t;

  vec_t vtab[$];

  ps2_scan_ctrl #(.FIFO_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_brk     (evt_brk),
    .bat_ok      (bat_ok),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .overflow    (overflow),
    .rx_flush    (rx_flush),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic [1:0] bad);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    case (bad)
      2'd1: f[9]  = ~f[9];
      2'd2: f[0]  = 1'b1;
      2'd3: f[10] = 1'b0;
      default: ;
    endcase
    return f;
  endfunction

  function automatic vec_t mk(input logic [7:0] b, input logic [1:0] bad, input logic has_evt,
                              input logic [9:0] evt, input logic exp_err, input logic exp_flush);
    vec_t v;
    v.b = b; v.bad = bad; v.has_evt = has_evt; v.evt = evt;
    v.exp_err = exp_err; v.exp_flush = exp_flush;
    return v;
  endfunction

  // Driver tasks: called just after a rising edge, return just after the
  // edge that captured the frame.
  task automatic send(input logic [7:0] b, input logic [1:0] bad);
    frame_data  = make_frame(b, bad);
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_err_cnt = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check(name, exp_q.size(), 0);
  endtask

  // Scoreboard: compare the head on every accepted transfer
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_evt: got %0h expected none", {evt_ext, evt_brk, evt_code});
      end else begin
        check("evt", {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int got_k;

    vtab.push_back(mk(8'h1C, 0, 1, {2'b00, 8'h1C}, 0, 0));
    vtab.push_back(mk(8'hF0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'h1C, 0, 1, {2'b01, 8'h1C}, 0, 0));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'hF0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'h75, 0, 1, {2'b11, 8'h75}, 0, 0));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'h74, 0, 1, {2'b10, 8'h74}, 0, 0));
    vtab.push_back(mk(8'h1C, 1, 0, 10'h0,          1, 1));
    vtab.push_back(mk(8'h1C, 0, 1, {2'b00, 8'h1C}, 0, 0));
    vtab.push_back(mk(8'hAA, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'hFA, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'h00, 0, 0, 10'h0,          1, 0));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          1, 0));
    vtab.push_back(mk(8'h6B, 0, 1, {2'b10, 8'h6B}, 0, 0));
    vtab.push_back(mk(8'hF0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          1, 0));
    vtab.push_back(mk(8'h1C, 0, 1, {2'b00, 8'h1C}, 0, 0));
    vtab.push_back(mk(8'h1C, 2, 0, 10'h0,          1, 1));
    vtab.push_back(mk(8'h5A, 3, 0, 10'h0,          1, 1));
    vtab.push_back(mk(8'hE0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'hFF, 0, 0, 10'h0,          1, 0));
    vtab.push_back(mk(8'h29, 0, 1, {2'b00, 8'h29}, 0, 0));
    vtab.push_back(mk(8'hF0, 0, 0, 10'h0,          0, 0));
    vtab.push_back(mk(8'h00, 0, 0, 10'h0,          1, 0));
    vtab.push_back(mk(8'h32, 0, 1, {2'b00, 8'h32}, 0, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_head",  {evt_ext, evt_brk, evt_code}, 0);
    check("rst_bat_ok",    bat_ok, 0);
    check("rst_err",       {err_pulse, rx_flush, overflow}, 0);
    check("rst_err_cnt",   err_cnt, 0);

    // Latency: strobe in N, evt_valid in N+1, nothing during N
    frame_data  = make_frame(8'h1C, 0);
    frame_valid = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    #1 check("no_fallthrough", evt_valid, 0);
    @(posedge clk);
    #1 frame_valid = 1'b0;
    check("latency_valid", evt_valid, 1);
    drain("drain_latency");

    // Table-driven vectors
    for (int i = 0; i < vtab.size(); i++) begin
      if (vtab[i].has_evt) exp_q.push_back(vtab[i].evt);
      if (vtab[i].exp_err) exp_err_cnt++;
      send(vtab[i].b, vtab[i].bad);
      check($sformatf("v%0d_err_pulse", i), err_pulse, vtab[i].exp_err);
      check($sformatf("v%0d_rx_flush", i),  rx_flush,  vtab[i].exp_flush);
    end
    drain("drain_table");
    check("table_err_cnt", err_cnt, exp_err_cnt);
    check("table_bat_ok",  bat_ok, 1);

    // Timeout after E0
    do_reset();
    send(8'hE0, 0);
    got_k = -1;
    for (int k = 1; k <= TO + 5 && got_k < 0; k++) begin
      @(posedge clk);
      #1 if (err_pulse) got_k = k;
    end
    check("timeout_edge", got_k, TO + 1);
    check("timeout_no_flush", rx_flush, 0);
    exp_err_cnt++;
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0);
    check("post_timeout_err", err_pulse, 0);
    drain("drain_timeout");

    // Good frame arriving on the timeout cycle is decoded from IDLE
    send(8'hE0, 0);
    repeat (TO) @(posedge clk);
    #1;
    exp_q.push_back({2'b00, 8'h1C});
    exp_err_cnt++;
    send(8'h1C, 0);
    check("to_same_cycle_err", err_pulse, 1);
    drain("drain_to_same");
    check("timeout_err_cnt", err_cnt, exp_err_cnt);

    // Overflow: 5 presses with consumer stalled
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(1, 8'h7F));
      if (i < 4) exp_q.push_back({2'b00, b});
      send(b, 0);
      check($sformatf("ovf_pulse_%0d", i), err_pulse, (i == 4));
    end
    check("ovf_flag", overflow, 1);
    check("ovf_err_cnt", err_cnt, 1);
    evt_ready = 1'b1;
    drain("drain_ovf");

    // Full FIFO with a pop in the same cycle as a push
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      exp_q.push_back({2'b00, b});
      if (i == 4) evt_ready = 1'b1;
      send(b, 0);
    end
    check("full_pop_overflow", overflow, 0);
    check("full_pop_err", err_pulse, 0);
    drain("drain_full_pop");
    check("full_pop_err_cnt", err_cnt, 0);

    // Reset in the middle of a prefix sequence
    send(8'hE0, 0);
    send(8'h00, 0);
    send(8'hE0, 0);
    do_reset();
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_err_cnt",   err_cnt, 0);
    check("midrst_flush",     {rx_flush, err_pulse}, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0);
    drain("drain_midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
